// File: rtl/div_iterative_unit_if.sv
// Issue and writeback handshake bundle for div_iterative_unit.
// The slave modport is the divider itself; the master is issue/writeback logic.
interface div_iterative_unit_if #(
    parameter int XLEN = 32,
    parameter int ID_W = 3
);
    logic            issue_valid;
    logic            issue_ready;
    logic [2:0]      issue_fn3;
    logic [XLEN-1:0] issue_rs1;
    logic [XLEN-1:0] issue_rs2;
    logic [ID_W-1:0] issue_id;
    logic            flush;
    logic            wb_valid;
    logic            wb_ack;
    logic [XLEN-1:0] wb_data;
    logic [ID_W-1:0] wb_id;

    modport master (
        output issue_valid, issue_fn3, issue_rs1, issue_rs2, issue_id, flush, wb_ack,
        input  issue_ready, wb_valid, wb_data, wb_id
    );

    modport slave (
        input  issue_valid, issue_fn3, issue_rs1, issue_rs2, issue_id, flush, wb_ack,
        output issue_ready, wb_valid, wb_data, wb_id
    );
endinterface

// File: rtl/div_iterative_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional last-result reuse is enabled by defining DIV_OPERAND_REUSE_EN.
module div_iterative_unit #(
    parameter int XLEN = 32,
    parameter int ID_W = 3
) (
    input logic               clk,
    input logic               rst,
    div_iterative_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_issue_ready;
    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_data;
    logic [ID_W-1:0] r_wb_id;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_sel_rem;

    logic            w_accept;
    logic            w_signed;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic [XLEN-1:0] w_rs1_mag;
    logic [XLEN-1:0] w_rs2_mag;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_data;
    logic [XLEN-1:0] w_direct;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_final;

    assign bus.issue_ready = r_issue_ready;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_id       = r_wb_id;

    // Operand decode, magnitudes and RISC-V special-case results
    always_comb begin
        w_accept  = bus.issue_valid & r_issue_ready & ~bus.flush;
        w_signed  = ~bus.issue_fn3[0];
        w_rs1_neg = w_signed & bus.issue_rs1[XLEN-1];
        w_rs2_neg = w_signed & bus.issue_rs2[XLEN-1];
        w_rs1_mag = w_rs1_neg ? -bus.issue_rs1 : bus.issue_rs1;
        w_rs2_mag = w_rs2_neg ? -bus.issue_rs2 : bus.issue_rs2;
        w_div0    = (bus.issue_rs2 == '0);
        w_ovf     = w_signed && (bus.issue_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.issue_rs2 == '1);
        w_special = w_div0 | w_ovf;
        if (w_div0) begin
            w_special_res = bus.issue_fn3[1] ? bus.issue_rs1 : {XLEN{1'b1}};
        end else begin
            w_special_res = bus.issue_fn3[1] ? {XLEN{1'b0}} : bus.issue_rs1;
        end
        if (w_special) begin
            w_direct = w_special_res;
        end else begin
            w_direct = w_hit_data;
        end
    end

    // One restoring step plus sign fix-up of the step's outcome
    always_comb begin
        w_rem_sh = {r_rem, r_quo[XLEN-1]};
        w_trial  = w_rem_sh - {1'b0, r_dvs};
        if (!w_trial[XLEN]) begin
            w_rem_nx = w_trial[XLEN-1:0];
            w_quo_nx = {r_quo[XLEN-2:0], 1'b1};
        end else begin
            w_rem_nx = w_rem_sh[XLEN-1:0];
            w_quo_nx = {r_quo[XLEN-2:0], 1'b0};
        end
        w_q_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_r_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_final = r_sel_rem ? w_r_fix : w_q_fix;
    end

`ifdef DIV_OPERAND_REUSE_EN
    logic [XLEN-1:0] r_op_rs1;
    logic [XLEN-1:0] r_op_rs2;
    logic            r_op_uns;
    logic [XLEN-1:0] r_last_rs1;
    logic [XLEN-1:0] r_last_rs2;
    logic            r_last_uns;
    logic [XLEN-1:0] r_last_q;
    logic [XLEN-1:0] r_last_r;
    logic            r_reuse_vld;

    // Hit when the raw operands and signedness match the last iterated result
    always_comb begin
        w_hit      = r_reuse_vld && (bus.issue_rs1 == r_last_rs1) &&
                     (bus.issue_rs2 == r_last_rs2) && (bus.issue_fn3[0] == r_last_uns);
        w_hit_data = bus.issue_fn3[1] ? r_last_r : r_last_q;
    end

    // Capture operands on accept and publish them with results on BUSY -> DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_rs1    <= '0;
            r_op_rs2    <= '0;
            r_op_uns    <= 1'b0;
            r_last_rs1  <= '0;
            r_last_rs2  <= '0;
            r_last_uns  <= 1'b0;
            r_last_q    <= '0;
            r_last_r    <= '0;
            r_reuse_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_rs1 <= bus.issue_rs1;
                r_op_rs2 <= bus.issue_rs2;
                r_op_uns <= bus.issue_fn3[0];
            end
            if (r_state == ST_BUSY) begin
                if (bus.flush) begin
                    r_reuse_vld <= 1'b0;
                end else if (r_cnt == '0) begin
                    r_last_rs1  <= r_op_rs1;
                    r_last_rs2  <= r_op_rs2;
                    r_last_uns  <= r_op_uns;
                    r_last_q    <= w_q_fix;
                    r_last_r    <= w_r_fix;
                    r_reuse_vld <= 1'b1;
                end
            end
        end
    end
`else
    // No stored result: never a reuse hit
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
    end
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_issue_ready <= 1'b1;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_id       <= '0;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_sel_rem     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_issue_ready <= 1'b0;
                        r_wb_id       <= bus.issue_id;
                        if (w_special || w_hit) begin
                            r_state    <= ST_DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_direct;
                        end else begin
                            r_state   <= ST_BUSY;
                            r_cnt     <= CNT_W'(XLEN-1);
                            r_rem     <= '0;
                            r_quo     <= w_rs1_mag;
                            r_dvs     <= w_rs2_mag;
                            r_neg_q   <= w_rs1_neg ^ w_rs2_neg;
                            r_neg_r   <= w_rs1_neg;
                            r_sel_rem <= bus.issue_fn3[1];
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        r_state       <= ST_IDLE;
                        r_issue_ready <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == '0) begin
                            r_state    <= ST_DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_final;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.flush || bus.wb_ack) begin
                        r_state       <= ST_IDLE;
                        r_wb_valid    <= 1'b0;
                        r_issue_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_issue_ready <= 1'b1;
                    r_wb_valid    <= 1'b0;
                    r_cnt         <= '0;
                end
            endcase
        end
    end

    div_iterative_unit_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_fn3   (bus.issue_fn3)
    );
endmodule

// Checker: only the divide half of the M-extension fn3 space may be offered.
module div_iterative_unit_chk (
    input logic       clk,
    input logic       rst,
    input logic       issue_valid,
    input logic [2:0] issue_fn3
);
    a_fn3_legal: assert property (@(posedge clk) disable iff (rst)
        issue_valid |-> issue_fn3[2]);
endmodule

// File: tb/tb_div_iterative_unit.sv
// Scoreboard bench for div_iterative_unit; expected results come from constants
// and a behavioural model built on the language's / and % operators.
module tb_div_iterative_unit;
    localparam int XLEN = 32;
    localparam int ID_W = 3;
`ifdef DIV_OPERAND_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 33;
`endif

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [ID_W-1:0] id;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb_q[$];

    div_iterative_unit_if #(.XLEN(XLEN), .ID_W(ID_W)) bus ();

    div_iterative_unit #(.XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (fn[0]) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return fn[1] ? r : q;
    endfunction

    // Issue one op at a negedge, wait for its result, check latency/data/id, then ack.
    task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] id,
                          input logic [31:0] exp_data, input int exp_lat, input int hold);
        sb_t e;
        int  lat;
        chk({tag, "_ready_in"}, bus.issue_ready, 1);
        bus.issue_valid = 1'b1;
        bus.issue_fn3   = fn;
        bus.issue_rs1   = a;
        bus.issue_rs2   = b;
        bus.issue_id    = id;
        e.data = exp_data;
        e.id   = id;
        sb_q.push_back(e);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        lat = 1;
        if (exp_lat > 1) chk({tag, "_busy_ready"}, bus.issue_ready, 0);
        while (!bus.wb_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.wb_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            void'(sb_q.pop_front());
            return;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        e = sb_q.pop_front();
        chk({tag, "_data"}, bus.wb_data, e.data);
        chk({tag, "_id"}, bus.wb_id, e.id);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.wb_valid, 1);
            chk({tag, "_hold_data"}, bus.wb_data, e.data);
        end
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.wb_ack = 1'b0;
        chk({tag, "_ack_drop"}, bus.wb_valid, 0);
        chk({tag, "_ready_out"}, bus.issue_ready, 1);
    endtask

    // Accept an op, then hit it with flush or reset in cycle 10 (accept cycle is 0).
    task automatic abort_op(input bit use_rst);
        int seen;
        bus.issue_valid = 1'b1;
        bus.issue_fn3   = 3'b100;
        bus.issue_rs1   = 32'd1000;
        bus.issue_rs2   = 32'd3;
        bus.issue_id    = 3'd5;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        repeat (9) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else bus.flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.flush = 1'b0;
        chk("abort_ready", bus.issue_ready, 1);
        chk("abort_valid", bus.wb_valid, 0);
        if (use_rst) begin
            chk("abort_rst_data", bus.wb_data, 0);
            chk("abort_rst_id", bus.wb_id, 0);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.wb_valid) seen++;
        end
        chk("abort_no_wb", seen, 0);
    endtask

    initial begin
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bus.issue_valid = 1'b0;
        bus.issue_fn3   = 3'b100;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_id    = '0;
        bus.flush       = 1'b0;
        bus.wb_ack      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.issue_ready, 1);
        chk("rst_valid", bus.wb_valid, 0);
        chk("rst_data", bus.wb_data, 0);
        chk("rst_id", bus.wb_id, 0);

        run_op("div_100_7", 3'b100, 32'd100, 32'd7, 3'd3, 32'd14, 33, 5);
        run_op("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 3'd4, 32'hFFFF_FFFE, 33, 0);
        // 4294967196 / 7 = 613566742
        run_op("divu_m100_7", 3'b101, 32'hFFFF_FF9C, 32'd7, 3'd1, 32'h2492_4916, 33, 0);
        run_op("div_by0", 3'b100, 32'd5, 32'd0, 3'd2, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 3'd6, 32'd5, 1, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 3'd7, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 3'd0, 32'd0, 1, 0);

        abort_op(1'b0);
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 3'd2, 32'd3, 33, 0);
        abort_op(1'b1);

        // flush beats issue_valid in IDLE: a div-by-0 op would show wb_valid next cycle
        bus.issue_valid = 1'b1;
        bus.issue_fn3   = 3'b100;
        bus.issue_rs1   = 32'd1;
        bus.issue_rs2   = 32'd0;
        bus.flush       = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        chk("flush_idle_ready", bus.issue_ready, 1);
        chk("flush_idle_valid", bus.wb_valid, 0);

        // flush together with wb_ack in DONE
        bus.issue_valid = 1'b1;
        bus.issue_id    = 3'd6;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        chk("flush_ack_valid", bus.wb_valid, 1);
        chk("flush_ack_data", bus.wb_data, 32'hFFFF_FFFF);
        bus.flush  = 1'b1;
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.flush  = 1'b0;
        bus.wb_ack = 1'b0;
        chk("flush_ack_drop", bus.wb_valid, 0);
        chk("flush_ack_ready", bus.issue_ready, 1);

        run_op("reuse_div", 3'b100, 32'd100, 32'd7, 3'd1, 32'd14, 33, 0);
        run_op("reuse_rem", 3'b110, 32'd100, 32'd7, 3'd2, 32'd2, REUSE_LAT, 0);
        run_op("reuse_remu", 3'b111, 32'd100, 32'd7, 3'd3, 32'd2, 33, 0);

        for (int i = 0; i < 8; i++) begin
            fn = 3'(4 + $urandom_range(0, 3));
            a  = $urandom();
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom() : $urandom_range(1, 1000));
            if (i == 5) b = -b;
            lat = (b == 32'd0) ? 1 : 33;
            run_op("rand", fn, a, b, 3'(i), ref_div(fn, a, b), lat, 0);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
